// File: rtl/adder_rr_scheduler_if.sv
// Requester, adder and response signals of the shared-adder scheduler.
// slave is the scheduler's view; master is the requesters/adder side.
interface adder_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_cin;
  logic [NREQ-1:0]            req_ready;
  logic                       add_valid;
  logic [WIDTH-1:0]           add_a;
  logic [WIDTH-1:0]           add_b;
  logic                       add_cin;
  logic [WIDTH-1:0]           add_sum;
  logic                       add_cout;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [NREQ-1:0][WIDTH-1:0] rsp_sum;
  logic [NREQ-1:0]            rsp_cout;
  logic [NREQ-1:0]            busy;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_valid, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_valid, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined adder between NREQ requesters,
// with a tag pipeline matched to adder latency and per-requester response slots.

module adder_rr_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_acc,
  input  logic             i_cap,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  input  logic             i_rsp_ready,
  output logic             o_busy,
  output logic             o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_sum,
  output logic             o_rsp_cout
);
  logic             r_busy;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             w_hs;

  assign w_hs = r_rsp_valid & i_rsp_ready;

  // busy spans accept through response handshake, so one op outstanding max
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      if (i_acc)     r_busy <= 1'b1;
      else if (w_hs) r_busy <= 1'b0;
      if (i_cap) begin
        r_rsp_valid <= 1'b1;
        r_rsp_sum   <= i_sum;
        r_rsp_cout  <= i_cout;
      end else if (w_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst && i_cap) assert (r_busy && !r_rsp_valid);
    if (rst && i_acc) assert (!r_busy);
  end

  assign o_busy      = r_busy;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
endmodule

module adder_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_rr_scheduler_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  logic [NREQ-1:0]            w_busy;
  logic [NREQ-1:0]            w_elig;
  logic [NREQ-1:0]            w_grant;
  logic [NREQ-1:0]            w_cap;
  logic [NREQ-1:0]            w_rsp_valid;
  logic [NREQ-1:0][WIDTH-1:0] w_rsp_sum;
  logic [NREQ-1:0]            w_rsp_cout;
  logic                       w_any;
  logic [IW-1:0]              w_gidx;
  logic [IW:0]                w_sum;
  logic [IW-1:0]              w_idx;
  logic [IW-1:0]              r_ptr;
  op_t                        w_op;
  op_t                        r_op;
  logic [LAT:0]               r_vld_pipe;
  logic [LAT:0][IW-1:0]       r_id_pipe;

  assign w_elig = bus.req_valid & ~w_busy;

  // first eligible index after r_ptr, wrapping mod NREQ
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      w_idx = w_sum[IW-1:0];
      if (!w_any && w_elig[w_idx]) begin
        w_any          = 1'b1;
        w_gidx         = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_op     = '0;
    w_op.a   = bus.req_a[w_gidx];
    w_op.b   = bus.req_b[w_gidx];
    w_op.cin = bus.req_cin[w_gidx];
  end

  // operands only load on acceptance so idle cycles leave the adder inputs quiet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= IW'(NREQ-1);
      r_op       <= '0;
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LAT-1:0], w_any};
      r_id_pipe  <= {r_id_pipe[LAT-1:0], w_gidx};
      if (w_any) begin
        r_ptr <= w_gidx;
        r_op  <= w_op;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign w_cap[i] = r_vld_pipe[LAT] && (r_id_pipe[LAT] == IW'(i));
    adder_rr_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_acc       (w_grant[i]),
      .i_cap       (w_cap[i]),
      .i_sum       (bus.add_sum),
      .i_cout      (bus.add_cout),
      .i_rsp_ready (bus.rsp_ready[i]),
      .o_busy      (w_busy[i]),
      .o_rsp_valid (w_rsp_valid[i]),
      .o_rsp_sum   (w_rsp_sum[i]),
      .o_rsp_cout  (w_rsp_cout[i])
    );
  end

  // grant is masked during reset since eligibility alone does not see rst
  assign bus.req_ready = rst ? w_grant : '0;
  assign bus.add_valid = r_vld_pipe[0];
  assign bus.add_a     = r_op.a;
  assign bus.add_b     = r_op.b;
  assign bus.add_cin   = r_op.cin;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_sum   = w_rsp_sum;
  assign bus.rsp_cout  = w_rsp_cout;
  assign bus.busy      = w_busy;
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one pipelined 32-bit KPG adder between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Issues operands to the adder and tracks in-flight operations in a tag pipeline matched to the adder latency.
- Captures each sum into a per-requester response register, then hands it back with its own valid/ready handshake.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/sum width
LAT, 2, adder latency: cycles from add_valid/operands registered to add_sum/add_cout valid

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation request
req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
req_cin  in  NREQ  carry-in per requester
req_ready  out  NREQ  one-hot grant; accept when req_valid[i]&req_ready[i]
add_valid  out  1  operands on add_a/add_b/add_cin are a real operation
add_a  out  WIDTH  registered operand A to adder
add_b  out  WIDTH  registered operand B to adder
add_cin  out  1  registered carry-in to adder
add_sum  in  WIDTH  adder result, valid LAT cycles after issue
add_cout  in  1  adder carry-out
rsp_valid  out  NREQ  per-requester result available
rsp_ready  in  NREQ  requester consumes result
rsp_sum  out  NREQ*WIDTH  per-requester held sum, same packing
rsp_cout  out  NREQ  per-requester held carry-out
busy  out  NREQ  requester has an op in flight or an unconsumed result

Behaviour:
- Reset (rst=0, async): req_ready=0, add_valid=0, add_a=add_b=0, add_cin=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, busy=0. The tag pipeline is cleared and the RR pointer is set to NREQ-1, so requester 0 has first priority.
- Reset mid-operation drops all in-flight ops. No response is produced for them.
- Eligibility: elig[i] = req_valid[i] & ~busy[i]. Each requester has at most one op outstanding.
- Arbitration is combinational. req_ready is one-hot (or zero): the first eligible index searching ptr+1, ptr+2, … mod NREQ. req_ready never depends on rsp_ready.
- On acceptance of requester g at cycle T:
  - ptr <= g, busy[g] <= 1.
  - add_a/add_b/add_cin <= req operands of g; add_valid=1 during T+1.
  - Tag {valid, g} enters a LAT-deep shift register.
- No acceptance at T: add_valid=0 during T+1. Operands hold their previous values (no toggling).
- Return: when the tag exits the shift register (cycle T+1+LAT, coincident with add_sum valid):
  - rsp_sum[g] <= add_sum, rsp_cout[g] <= add_cout.
  - rsp_valid[g]=1 from T+2+LAT.
  - Total request-accept to rsp_valid latency = LAT+2 cycles.
- Response hold: rsp_valid[i] stays high and rsp_sum/rsp_cout stay stable until rsp_ready[i]. On the handshake cycle rsp_valid[i] <= 0 and busy[i] <= 0.
- A requester may be re-granted in the cycle after its response handshake, not the same cycle.
- Throughput: one issue per cycle when different requesters are eligible. Per-requester throughput is one op per LAT+3 cycles minimum.
- Simultaneous events:
  - A capture for requester i and a handshake for requester j≠i in the same cycle are independent.
  - Capture into an already-valid rsp slot cannot occur (busy invariant). An assertion must check this.
- Arithmetic: sum/cout are passed through unmodified as unsigned WIDTH-bit plus carry. Signed interpretation is the requester's concern. Overflow is not flagged.
- req_valid may drop without acceptance. No request state is held for unaccepted requests.

Test Plan:
- Reset then a single op: req 0 {a=-36, b=36, cin=0}, rsp_ready=1 → req_ready[0]=1 at T; rsp_valid[0] at T+4 with rsp_sum=0, rsp_cout=1.
- All 4 requesters valid continuously with a=352+i, b=18 → grants in order 0,1,2,3,0…, one per cycle. Requester i receives 370+i. No requester is granted while busy.
- Back-pressure: req 1 {4, 67}, rsp_ready[1]=0 for 10 cycles → rsp_sum[1]=71 held stable, busy[1]=1, req_ready[1]=0 despite req_valid[1]. Release → handshake; grant again at the next cycle.
- Wrap-around: ptr=3, requesters 0 and 3 valid → grant 0 first, then 3.
- Carry boundary: a=0xFFFFFFFF, b=0, cin=1 → rsp_sum=0, rsp_cout=1. Also a=0x7FFFFFFF, b=1 → 0x80000000, cout=0.
- Assert rst low with 2 ops in flight and 1 held response → all outputs are 0 immediately. After release, no stale rsp_valid appears over the next LAT+2 cycles.
